// File: rtl/instr_trace_buffer.sv
// Commit-trace capture FIFO: samples core PC/instruction pairs and drains them over a valid/ready stream.
// Optional per-entry cycle stamps are enabled by defining TRACE_CYCLE_STAMP_EN.
module instr_trace_buffer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned STAMP_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     drop_repeat,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              inst_in,
    input  logic                     clear,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_pc,
    output logic [31:0]              m_inst,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [STAMP_W-1:0]       m_stamp,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STAMP_W == 0) begin : g_cfg_check
        $error("instr_trace_buffer: DEPTH must be a power of two >= 2 and STAMP_W nonzero");
    end

    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             last_vld_q, last_vld_d;
    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_pc_q, m_pc_d;
    logic [31:0]      m_inst_q, m_inst_d;

    logic cap_c, pop_c, push_c, drop_c, wr_en_c, head_new_c;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [STAMP_W-1:0] stamp_mem_q [DEPTH];
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [STAMP_W-1:0] m_stamp_q, m_stamp_d;
`endif

    // Handshake and capture qualification
    assign cap_c   = trace_en && !(drop_repeat && last_vld_q && (pc_in == last_pc_q));
    assign pop_c   = m_valid_q && m_ready;
    assign push_c  = cap_c && ((level_q < LVL_W'(DEPTH)) || pop_c);
    assign drop_c  = cap_c && !push_c;
    assign wr_en_c = push_c && !clear && !rst;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        last_pc_d    = last_pc_q;
        last_vld_d   = last_vld_q;
        m_valid_d    = 1'b0;
        m_pc_d       = 32'd0;
        m_inst_d     = 32'd0;
        head_new_c   = 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
        stamp_d      = stamp_q + STAMP_W'(1);
        m_stamp_d    = '0;
`endif
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = 16'd0;
            last_vld_d   = 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
            stamp_d      = '0;
`endif
        end else begin
            if (cap_c) begin
                last_pc_d  = pc_in;
                last_vld_d = 1'b1;
            end
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
            if (drop_c) begin
                overflow_d = 1'b1;
                if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            end
            // The entry being written this edge becomes head when nothing older remains
            head_new_c = push_c && (wr_ptr_q == rd_ptr_d);
            if (level_d != '0) begin
                m_valid_d = 1'b1;
                if (head_new_c) begin
                    m_pc_d   = pc_in;
                    m_inst_d = inst_in;
`ifdef TRACE_CYCLE_STAMP_EN
                    m_stamp_d = stamp_q;
`endif
                end else begin
                    m_pc_d   = pc_mem_q[rd_ptr_d];
                    m_inst_d = inst_mem_q[rd_ptr_d];
`ifdef TRACE_CYCLE_STAMP_EN
                    m_stamp_d = stamp_mem_q[rd_ptr_d];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
            last_pc_q    <= 32'd0;
            last_vld_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_pc_q       <= 32'd0;
            m_inst_q     <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            last_pc_q    <= last_pc_d;
            last_vld_q   <= last_vld_d;
            m_valid_q    <= m_valid_d;
            m_pc_q       <= m_pc_d;
            m_inst_q     <= m_inst_d;
        end
    end

    // Entry storage needs no reset: only slots below level are ever presented
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            pc_mem_q[wr_ptr_q]   <= pc_in;
            inst_mem_q[wr_ptr_q] <= inst_in;
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_q   <= '0;
            m_stamp_q <= '0;
        end else begin
            stamp_q   <= stamp_d;
            m_stamp_q <= m_stamp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) stamp_mem_q[wr_ptr_q] <= stamp_q;
    end

    assign m_stamp = m_stamp_q;
`endif

    assign m_valid    = m_valid_q;
    assign m_pc       = m_pc_q;
    assign m_inst     = m_inst_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/instr_trace_buffer.md
# instr_trace_buffer

Commit-trace capture stage sitting directly downstream of the single-cycle RISC-V core. Samples the core's fetched PC/instruction pair (`PC_out_top`, `Instruction_out_top`) each enabled cycle and pushes it into a circular FIFO. The FIFO drains over a valid/ready stream to a debug consumer (UART dumper, testbench monitor). Tracks overflow and dropped samples so a slow consumer never stalls the core.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `STAMP_W`, 32, cycle-stamp width (used only with `TRACE_CYCLE_STAMP_EN`)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `trace_en`  in  1  capture enable
- `drop_repeat`  in  1  suppress capture when `pc_in` equals the last captured PC
- `pc_in`  in  32  core PC (`PC_out_top`)
- `inst_in`  in  32  core instruction (`Instruction_out_top`)
- `clear`  in  1  synchronous flush of FIFO and status
- `m_valid`  out  1  output entry available
- `m_ready`  in  1  consumer accepts entry
- `m_pc`  out  32  entry PC
- `m_inst`  out  32  entry instruction
- `m_stamp`  out  STAMP_W  entry cycle stamp (port present only with `TRACE_CYCLE_STAMP_EN`)
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: at least one sample dropped since reset/clear
- `drop_count`  out  16  dropped-sample count, saturates at 0xFFFF

## Operation
- Capture request `cap = trace_en && !(drop_repeat && last_vld && pc_in == last_pc)`.
- On `cap`: `last_pc <= pc_in`, `last_vld <= 1`, regardless of whether the push succeeds.
- Push when `cap && (level < DEPTH || pop)`; `pop = m_valid && m_ready`.
- Full with no pop: sample dropped, `overflow <= 1`, `drop_count` +1 (saturating).
- Write/read pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH; `level` tracks occupancy, so full (DEPTH) and empty (0) are unambiguous.
- Show-ahead output: `m_pc`/`m_inst`/`m_stamp` = head entry while `m_valid`. All three read 0 when `m_valid`=0.
- Stream rule: while `m_valid && !m_ready`, outputs are held stable; `m_valid` never drops without a pop.
- `level` next = `level + push − pop`.
- `clear`: empties FIFO, zeroes pointers, `level`, `overflow`, `drop_count`, `last_vld`, and stamp counter. Has priority over a same-cycle push/pop; the sample in that cycle is discarded and not counted as dropped.
- `rst`: same effect as `clear`, plus all outputs at their reset values.

## Timing
- Reset values: `m_valid`=0, `m_pc`=0, `m_inst`=0, `m_stamp`=0, `level`=0, `overflow`=0, `drop_count`=0.
- Latency: a sample captured at edge N is visible on `m_valid`/`m_*` after edge N (cycle N+1). There is no same-cycle bypass, even when empty.
- Simultaneous push and pop:
  - When full: both succeed, `level` stays DEPTH, nothing dropped.
  - When `level`=1: the pushed entry becomes head the next cycle, and `m_valid` stays 1.
- Pop takes effect at the edge where `m_valid && m_ready`; the next entry (if any) is presented the following cycle.
- `rst` asserted mid-drain: the FIFO is flushed at that edge, and `m_valid`=0 from the next cycle.

## Configuration
- `TRACE_CYCLE_STAMP_EN` defined:
  - A free-running `STAMP_W`-bit cycle counter counts from 0 after reset/clear, increments every cycle, and wraps at 2^STAMP_W.
  - The counter value in the capture cycle is stored with each entry and presented on `m_stamp`.
- Not defined: no counter, no stamp storage, no `m_stamp` port. All other behaviour is identical.

## Test plan
- Reset, then `trace_en`=1 for 3 cycles with PC 0x0/0x4/0x8 and `m_ready`=1 → `m_valid` rises one cycle after the first capture; entries out in order 0x0, 0x4, 0x8; `level` returns to 0.
- `m_ready`=0, 20 captures, DEPTH=16 → `level`=16, `overflow`=1, `drop_count`=4. Draining then yields the first 16 PCs in order.
- Full FIFO, capture and `m_ready`=1 in the same cycle → no drop, `level` stays 16, new PC is at the tail.
- `drop_repeat`=1, `pc_in` held at 0x10 for 5 cycles, then 0x14 → exactly 2 entries (0x10, 0x14).
- `m_ready` toggled randomly → `m_pc`/`m_inst` stable whenever `m_valid && !m_ready`; no loss, no duplication.
- With `TRACE_CYCLE_STAMP_EN`: captures at cycles 2 and 7 after reset → `m_stamp` = 2, then 7. Asserting `clear` mid-stream → `level`=0 and `overflow`=0 next cycle, and the stamp restarts at 0.
